// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared state encodings and handshake constants for the iterative divider
package div_iter_pkg;

    // Default operand width; the iteration count equals the width.
    localparam int DIV_WIDTH = 32;

    // State encoding is visible on the state port, so the values are fixed.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring shift/trial-subtract step
//
// Ports:
//   acc_i      in  2*WIDTH+1  {partial_rem, dividend} before the step
//   divisor_i  in  WIDTH      divisor magnitude
//   acc_o      out 2*WIDTH+1  {partial_rem, dividend/quotient} after the step
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc_i,
    input  logic [WIDTH-1:0]  divisor_i,
    output logic [2*WIDTH:0]  acc_o
);

    // Remainder field after the left shift. One extra bit above the stored
    // remainder keeps the comparison exact for divisors close to 2^WIDTH.
    logic [WIDTH+1:0] rem_shift;
    logic             trial_ok;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_shift = acc_i[2*WIDTH:WIDTH-1];
        trial_ok  = (rem_shift >= {2'b00, divisor_i});
        // When the trial succeeds the true difference is below the divisor,
        // so WIDTH+1 bits hold it without loss.
        trial     = rem_shift[WIDTH:0] - {1'b0, divisor_i};
        if (trial_ok) begin
            acc_o = {trial, acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {rem_shift[WIDTH:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Ports:
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous active-high reset
//   signed_div_i  in   1        1 = signed divide, sampled at accept
//   opdata1_i     in   WIDTH    dividend, sampled at accept
//   opdata2_i     in   WIDTH    divisor, sampled at accept
//   start_i       in   1        request, held until ready_o is seen
//   annul_i       in   1        abort / flush
//   result_o      out  2*WIDTH  {remainder, quotient}; zero unless ready_o
//   ready_o       out  1        result valid
//   state         out  2        FSM state
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic [1:0]           state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]      acc_q, acc_d;
    logic [WIDTH-1:0]      divisor_q, divisor_d;
    logic                  sign1_q, sign1_d;
    logic                  sign2_q, sign2_d;
    logic                  signed_q, signed_d;
    logic [2*WIDTH-1:0]    result_q, result_d;
    logic                  ready_q, ready_d;

    logic [2*WIDTH:0]      acc_step;
    logic [WIDTH-1:0]      mag1;
    logic [WIDTH-1:0]      mag2;
    logic [WIDTH-1:0]      quot_raw;
    logic [WIDTH-1:0]      rem_raw;
    logic [WIDTH-1:0]      quot_fix;
    logic [WIDTH-1:0]      rem_fix;

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i     (acc_q),
        .divisor_i (divisor_q),
        .acc_o     (acc_step)
    );

    // Operand magnitudes. Negating the most negative value wraps back to
    // itself, which is the correct unsigned magnitude.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // Sign fix-up on the final step's output: quotient is negative when the
    // operand signs differ, remainder follows the dividend.
    always_comb begin
        quot_raw = acc_step[WIDTH-1:0];
        rem_raw  = acc_step[2*WIDTH-1:WIDTH];
        quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quot_raw : quot_raw;
        rem_fix  = (signed_q && sign1_q) ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        signed_d  = signed_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        acc_d     = {{(WIDTH+1){1'b0}}, mag1};
                        divisor_d = mag2;
                        sign1_d   = opdata1_i[WIDTH-1];
                        sign2_d   = opdata2_i[WIDTH-1];
                        signed_d  = signed_div_i;
                        cnt_d     = '0;
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    // The step taken on this edge is the last one.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            acc_q     <= '0;
            divisor_q <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            signed_q  <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            signed_q  <= signed_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign state    = state_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result_o;
    logic        ready_o;
    logic [1:0]  state;

    int pass_cnt;
    int total_cnt;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and waits (bounded) for ready_o; operands are
    // scrambled after the accept edge to show they are latched.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int rdy_edge, output logic [63:0] res);
        rdy_edge = -1;
        res      = '0;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                rdy_edge = e;
                res      = result_o;
                break;
            end
            if (e == 2) begin
                op1 = ~a;
                op2 = b + 32'd1;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (state !== 2'b00) $display("FAIL reset_state: got %b expected 00", state);
        else pass_cnt++;
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== 64'h0) $display("FAIL reset_result: got %h expected 0", result_o);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int          re;
        logic [63:0] res;
        run_op(1'b0, 32'd100, 32'd7, re, res);
        total_cnt++;
        if (re !== 33) $display("FAIL divu_latency: got edge %0d expected 33", re);
        else pass_cnt++;
        total_cnt++;
        if (res !== {32'd2, 32'd14}) $display("FAIL divu_100_7: got %h expected %h", res, {32'd2, 32'd14});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14} || state !== 2'b11)
            $display("FAIL divu_hold: got ready=%b result=%h state=%b expected 1 %h 11",
                     ready_o, result_o, state, {32'd2, 32'd14});
        else pass_cnt++;
        drop_start();
        total_cnt++;
        if (state !== 2'b00 || ready_o !== 1'b0 || result_o !== 64'h0)
            $display("FAIL divu_release: got state=%b ready=%b result=%h expected 00 0 0",
                     state, ready_o, result_o);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        int          re;
        logic [63:0] res;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, re, res);
        total_cnt++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || re !== 33)
            $display("FAIL div_neg7_2: got %h at edge %0d expected %h at 33",
                     res, re, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        else pass_cnt++;
        drop_start();
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, re, res);
        total_cnt++;
        if (res !== {32'd1, 32'h7FFF_FFFC})
            $display("FAIL divu_fff9_2: got %h expected %h", res, {32'd1, 32'h7FFF_FFFC});
        else pass_cnt++;
        drop_start();
    endtask

    task automatic test_byzero();
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (state !== 2'b01 || ready_o !== 1'b0)
            $display("FAIL byzero_edge1: got state=%b ready=%b expected 01 0", state, ready_o);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (state !== 2'b11 || ready_o !== 1'b1 || result_o !== 64'h0)
            $display("FAIL byzero_edge2: got state=%b ready=%b result=%h expected 11 1 0",
                     state, ready_o, result_o);
        else pass_cnt++;
        drop_start();
    endtask

    task automatic test_overflow();
        int          re;
        logic [63:0] res;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, re, res);
        total_cnt++;
        if (res !== {32'd0, 32'h8000_0000})
            $display("FAIL div_overflow: got %h expected %h", res, {32'd0, 32'h8000_0000});
        else pass_cnt++;
        drop_start();
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, re, res);
        total_cnt++;
        if (res !== {32'h8000_0000, 32'd0})
            $display("FAIL divu_8000_ffff: got %h expected %h", res, {32'h8000_0000, 32'd0});
        else pass_cnt++;
        drop_start();
    endtask

    task automatic test_annul();
        int          re;
        logic [63:0] res;
        logic        saw_ready;
        saw_ready = 1'b0;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw_ready = 1'b1;
        end
        total_cnt++;
        if (state !== 2'b10 || result_o !== 64'h0)
            $display("FAIL annul_in_on: got state=%b result=%h expected 10 0", state, result_o);
        else pass_cnt++;
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (state !== 2'b00 || ready_o !== 1'b0)
            $display("FAIL annul_free: got state=%b ready=%b expected 00 0", state, ready_o);
        else pass_cnt++;
        @(negedge clk);
        annul = 1'b0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) saw_ready = 1'b1;
        end
        total_cnt++;
        if (saw_ready !== 1'b0) $display("FAIL annul_no_ready: got ready seen=%b expected 0", saw_ready);
        else pass_cnt++;
        run_op(1'b0, 32'd9, 32'd3, re, res);
        total_cnt++;
        if (res !== {32'd0, 32'd3} || re !== 33)
            $display("FAIL after_annul_9_3: got %h at edge %0d expected %h at 33", res, re, {32'd0, 32'd3});
        else pass_cnt++;
        drop_start();
    endtask

    task automatic test_rst_mid();
        logic left_free;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (state !== 2'b00 || ready_o !== 1'b0 || result_o !== 64'h0)
            $display("FAIL rst_mid_on: got state=%b ready=%b result=%h expected 00 0 0",
                     state, ready_o, result_o);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op2 = 32'd3;
        left_free = 1'b0;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            if (state !== 2'b00) left_free = 1'b1;
        end
        total_cnt++;
        if (left_free !== 1'b0 || ready_o !== 1'b0)
            $display("FAIL start_with_annul: got left_free=%b ready=%b expected 0 0", left_free, ready_o);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_byzero();
        test_overflow();
        test_annul();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
